// File: rtl/vector_sweep_checker.sv
// vector_sweep_checker
//   Self-checking sweep wrapped around a small combinational circuit.
//   Drives every input combination 0 .. 2**N_IN-1 on vec_out. For each one it
//   waits SETTLE cycles, then samples dut_out in a single SAMPLE cycle. The
//   sampled bits build the observed truth table, which is compared bit by bit
//   against the expected table.
//
//   Valid/ready note: there is no backpressure. A sweep is requested by a
//   one-cycle start pulse, which is accepted only while busy=0 (IDLE or DONE).
//   The result outputs are valid while done=1 and are held until the next
//   accepted start or reset.
//
//   Optional build macro VECTOR_SWEEP_STOP_ON_FAIL_EN: when it is defined, the
//   first mismatching vector ends the sweep immediately, with pass=0. By
//   default (undefined) the full sweep always runs.
//
//   o_dbg_state exposes the FSM state (0 IDLE, 1 WAIT, 2 SAMPLE, 3 DONE).
module vector_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2**N_IN-1:0]  expected,
  output logic [N_IN-1:0]     vec_out,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  observed,
  output logic [N_IN:0]       mismatch_cnt,
  output logic [N_IN-1:0]     first_fail_idx,
  output logic                first_fail_valid,
  output logic [1:0]          o_dbg_state
);

  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
  localparam logic [3:0]      CNT_ONE  = 4'd1;
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   MIS_ONE  = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [N_IN-1:0]     r_vec;
  logic [2**N_IN-1:0]  r_obs;
  logic [N_IN:0]       r_mis_cnt;
  logic [N_IN-1:0]     r_ff_idx;
  logic                r_ff_valid;
  logic                r_pass;

  logic                w_launch;
  logic                w_mismatch;
  logic                w_last;
  logic                w_finish;

  // Start is honoured only while no sweep is running.
  assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mismatch = dut_out ^ expected[r_vec];
  assign w_last     = (r_vec == VEC_LAST);

`ifdef VECTOR_SWEEP_STOP_ON_FAIL_EN
  // End the sweep at the last vector, or at the first mismatch.
  assign w_finish = w_last || w_mismatch;
`else
  // End the sweep only after the last vector has been sampled.
  assign w_finish = w_last;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. WAIT lasts SETTLE cycles, because the counter is loaded
  // with SETTLE and WAIT is left when the counter reads 1.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_launch) w_next_state = S_WAIT;
      S_WAIT:   if (r_cnt == CNT_ONE) w_next_state = S_SAMPLE;
      S_SAMPLE: w_next_state = w_finish ? S_DONE : S_WAIT;
      S_DONE:   if (w_launch) w_next_state = S_WAIT;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath: vector stepping, settle counter, and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_vec      <= '0;
      r_obs      <= '0;
      r_mis_cnt  <= '0;
      r_ff_idx   <= '0;
      r_ff_valid <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_launch) begin
            r_cnt      <= SETTLE_L;
            r_vec      <= '0;
            r_obs      <= '0;
            r_mis_cnt  <= '0;
            r_ff_idx   <= '0;
            r_ff_valid <= 1'b0;
            r_pass     <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
        end
        S_SAMPLE: begin
          r_obs[r_vec] <= dut_out;
          if (w_mismatch) begin
            r_mis_cnt <= r_mis_cnt + MIS_ONE;
            if (!r_ff_valid) begin
              r_ff_idx   <= r_vec;
              r_ff_valid <= 1'b1;
            end
          end
          if (w_finish) begin
            // The final verdict includes the vector that is being sampled now.
            r_pass <= (r_mis_cnt == '0) && !w_mismatch;
          end else begin
            r_vec <= r_vec + VEC_ONE;
            r_cnt <= SETTLE_L;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign vec_out          = r_vec;
  assign busy             = (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign done             = (r_state == S_DONE);
  assign pass             = r_pass;
  assign observed         = r_obs;
  assign mismatch_cnt     = r_mis_cnt;
  assign first_fail_idx   = r_ff_idx;
  assign first_fail_valid = r_ff_valid;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Bench for vector_sweep_checker.
//   Two checker instances are used: one with SETTLE=1 and one with SETTLE=3.
//   Each drives its own model of the circuit under test, which is a 3-input
//   majority function. That circuit can be stuck at 0 or delayed by 1-2 cycles.
//   A behavioural model derives every output from the cycle number counted
//   since start was accepted.
module tb_vector_sweep_checker;

  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] expected = 8'h00;
  logic start1 = 1'b0, start3 = 1'b0;
  logic dut1, dut3;
  logic [2:0] vec1, vec3, ffi1, ffi3;
  logic busy1, busy3, done1, done3, pass1, pass3, ffv1, ffv3;
  logic [7:0] obs1, obs3;
  logic [3:0] mc1, mc3;
  logic [1:0] st1, st3;

  vector_sweep_checker #(.N_IN(3), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected),
    .vec_out(vec1), .dut_out(dut1), .busy(busy1), .done(done1), .pass(pass1),
    .observed(obs1), .mismatch_cnt(mc1), .first_fail_idx(ffi1),
    .first_fail_valid(ffv1), .o_dbg_state(st1));

  vector_sweep_checker #(.N_IN(3), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected),
    .vec_out(vec3), .dut_out(dut3), .busy(busy3), .done(done3), .pass(pass3),
    .observed(obs3), .mismatch_cnt(mc3), .first_fail_idx(ffi3),
    .first_fail_valid(ffv3), .o_dbg_state(st3));

  // Circuit under test: a majority function with an optional stuck-at-0 fault
  // and an optional 1- or 2-cycle output delay.
  function automatic logic maj(input logic [2:0] v);
    return ($countones(v) >= 2);
  endfunction

  bit stuck1 = 0, stuck3 = 0;
  int dly1 = 0, dly3 = 0;
  logic a1 = 0, b1 = 0, a3 = 0, b3 = 0;
  always @(posedge clk) begin
    a1 <= maj(vec1); b1 <= a1;
    a3 <= maj(vec3); b3 <= a3;
  end
  assign dut1 = stuck1 ? 1'b0 : (dly1 == 0) ? maj(vec1) : (dly1 == 1) ? a1 : b1;
  assign dut3 = stuck3 ? 1'b0 : (dly3 == 0) ? maj(vec3) : (dly3 == 1) ? a3 : b3;

  // Outputs of the instance that is currently under test.
  bit sel = 0;
  logic [2:0] m_vec, m_ffi;
  logic m_busy, m_done, m_pass, m_ffv;
  logic [7:0] m_obs;
  logic [3:0] m_mc;
  assign m_vec  = sel ? vec3 : vec1;
  assign m_ffi  = sel ? ffi3 : ffi1;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_pass = sel ? pass3 : pass1;
  assign m_ffv  = sel ? ffv3 : ffv1;
  assign m_obs  = sel ? obs3 : obs1;
  assign m_mc   = sel ? mc3 : mc1;

  // Scoreboard state.
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one sweep.
  //   mdl_samp[v] is the value that the circuit presents when vector v is sampled.
  //   mdl_t is the number of cycles from the accepting edge until DONE is entered.
  int mdl_settle = 1;
  int mdl_t = 0;
  int mdl_last = 0;
  logic [7:0] mdl_exp = 0, mdl_samp = 0;
  int last_vec1 = 0, last_vec3 = 0;
  int c = 0;
  int done_c = -1;
  bit chk_en = 0;

  task automatic set_model(input bit s, input int settle, input bit stuck,
                           input int dly, input logic [7:0] exp_tab);
    int prev, ff, nv;
    logic [7:0] fin;
    sel = s;
    mdl_settle = settle;
    mdl_exp = exp_tab;
    expected = exp_tab;
    if (s) begin stuck3 = stuck; dly3 = dly; prev = last_vec3; end
    else   begin stuck1 = stuck; dly1 = dly; prev = last_vec1; end
    // If the delay is longer than the settle time, the sampled value still
    // reflects the vector that was applied before the current one.
    for (int v = 0; v < NV; v++) begin
      if (stuck) mdl_samp[v] = 1'b0;
      else if (dly <= settle) mdl_samp[v] = maj(3'(v));
      else mdl_samp[v] = maj(3'((v == 0) ? prev : v - 1));
    end
    ff = -1;
    for (int v = 0; v < NV; v++)
      if (mdl_samp[v] != mdl_exp[v] && ff < 0) ff = v;
    mdl_t = NV * (settle + 1);
`ifdef VECTOR_SWEEP_STOP_ON_FAIL_EN
    if (ff >= 0) mdl_t = (ff + 1) * (settle + 1);
`endif
    nv = mdl_t / (settle + 1);
    mdl_last = nv - 1;
    fin = 8'h00;
    for (int v = 0; v < nv; v++) fin[v] = mdl_samp[v];
    exp_q.push_back(fin);
  endtask

  // Single compare process. c counts the cycles since the edge that accepted start.
  always @(negedge clk) begin : compare
    int s1, n, e_vec, e_mc, e_ffi;
    logic [7:0] e_obs;
    logic e_ffv, e_busy, e_done;
    if (chk_en) begin
      s1 = mdl_settle + 1;
      n = c / s1;
      if (n > mdl_t / s1) n = mdl_t / s1;
      e_vec = (c < mdl_t) ? c / s1 : mdl_t / s1 - 1;
      e_obs = 8'h00; e_mc = 0; e_ffv = 0; e_ffi = 0;
      for (int v = 0; v < n; v++) begin
        e_obs[v] = mdl_samp[v];
        if (mdl_samp[v] != mdl_exp[v]) begin
          e_mc++;
          if (!e_ffv) begin e_ffv = 1; e_ffi = v; end
        end
      end
      e_busy = (c < mdl_t);
      e_done = (c >= mdl_t);
      if (m_done && done_c < 0) done_c = c;
      chk("vec_out", m_vec, e_vec);
      chk("busy", m_busy, e_busy);
      chk("done", m_done, e_done);
      chk("pass", m_pass, e_done && (e_mc == 0));
      chk("observed", m_obs, e_obs);
      chk("mismatch_cnt", m_mc, e_mc);
      chk("first_fail_valid", m_ffv, e_ffv);
      chk("first_fail_idx", m_ffi, e_ffi);
      c++;
    end
  end

  // Pulse start for one cycle. The edge that follows samples it.
  task automatic launch();
    @(posedge clk); #1;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    c = 0; done_c = -1; chk_en = 1;
  endtask

  task automatic wait_c(input int n);
    for (int k = 0; k < 200 && c < n; k++) begin @(negedge clk); #1; end
    chk("wait_c_timeout", (c >= n), 1'b1);
  endtask

  task automatic finish_sweep();
    logic [7:0] fin;
    repeat (mdl_t + 3) @(negedge clk);
    #1 chk_en = 0;
    chk("done_seen", (done_c >= 0), 1'b1);
    fin = exp_q.pop_front();
    chk("final_observed", m_obs, fin);
    if (sel) last_vec3 = mdl_last; else last_vec1 = mdl_last;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"}, {vec1, vec3}, 0);
    chk({tag, "_busy"}, {busy1, busy3}, 0);
    chk({tag, "_done"}, {done1, done3}, 0);
    chk({tag, "_pass"}, {pass1, pass3}, 0);
    chk({tag, "_obs"}, {obs1, obs3}, 0);
    chk({tag, "_mc"}, {mc1, mc3}, 0);
    chk({tag, "_ffi"}, {ffi1, ffi3}, 0);
    chk({tag, "_ffv"}, {ffv1, ffv3}, 0);
    chk({tag, "_state"}, {st1, st3}, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit rs, rstk;
    int rd;
    logic [7:0] rexp;

    // Reset state.
    #12 chk_all_zero("reset");
    #5 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Scenario 1: majority circuit, expected table E8 -> clean pass at edge 17.
    set_model(0, 1, 0, 0, 8'hE8);
    launch(); finish_sweep();
    chk("s1_done_edge", done_c + 1, 17);
    chk("s1_pass", m_pass, 1'b1);
    chk("s1_observed", m_obs, 8'hE8);
    chk("s1_mc", m_mc, 0);
    chk("s1_ffv", m_ffv, 1'b0);

    // Scenario 2: circuit output stuck at 0.
    set_model(0, 1, 1, 0, 8'hE8);
    launch(); finish_sweep();
    chk("s2_observed", m_obs, 8'h00);
    chk("s2_ffi", m_ffi, 3);
    chk("s2_ffv", m_ffv, 1'b1);
    chk("s2_pass", m_pass, 1'b0);
`ifdef VECTOR_SWEEP_STOP_ON_FAIL_EN
    chk("s6_done_edge", done_c + 1, 9);
    chk("s6_vec", m_vec, 3);
    chk("s6_mc", m_mc, 1);
`else
    chk("s2_done_edge", done_c + 1, 17);
    chk("s2_mc", m_mc, 4);
`endif

    // Scenario 3: reset while vector 4 is applied, then a clean sweep.
    set_model(0, 1, 0, 0, 8'hE8);
    launch();
    wait_c(9);
    chk_en = 0;
    rst_n = 1'b0;
    #1 chk_all_zero("abort");
    @(posedge clk); #1 chk_all_zero("abort_hold");
    #2 rst_n = 1'b1;
    void'(exp_q.pop_front());
    last_vec1 = 0;
    set_model(0, 1, 0, 0, 8'hE8);
    launch(); finish_sweep();
    chk("s3_done_edge", done_c + 1, 17);
    chk("s3_pass", m_pass, 1'b1);

    // Scenario 4: a second start at vector 2 must be ignored.
    set_model(0, 1, 0, 0, 8'hE8);
    launch();
    wait_c(5);
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    finish_sweep();
    chk("s4_done_edge", done_c + 1, 17);
    chk("s4_observed", m_obs, 8'hE8);
    chk("s4_pass", m_pass, 1'b1);

    // Scenario 5: circuit output registered once or twice.
    set_model(1, 3, 0, 1, 8'hE8);
    launch(); finish_sweep();
    chk("s5_done_edge", done_c + 1, 33);
    chk("s5_pass_s3_d1", m_pass, 1'b1);
    set_model(0, 1, 0, 1, 8'hE8);
    launch(); finish_sweep();
    chk("s5_pass_s1_d1", m_pass, 1'b1);
    set_model(0, 1, 0, 2, 8'hE8);
    launch(); finish_sweep();
    chk("s5_pass_s1_d2", m_pass, 1'b0);

    // Randomized sweeps.
    for (int it = 0; it < 14; it++) begin
      rs = 1'($urandom_range(0, 1));
      rstk = ($urandom_range(0, 3) == 0);
      rd = $urandom_range(0, 2);
      rexp = $urandom_range(0, 1) ? 8'hE8 : 8'($urandom_range(0, 255));
      set_model(rs, rs ? 3 : 1, rstk, rd, rexp);
      launch(); finish_sweep();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
